uart_tx_queue: RTL
==================

// Module: uart_tx_queue
// PURPOSE
//  Byte FIFO and send sequencer between the byte-routing logic in system and a uart_tx instance.
//  Buffers write pulses (keyboard, board and switch bytes), so back-to-back events are no longer lost while uart_tx is busy.
//  Releases one byte at a time on uart_tx's data/en inputs and paces the releases on uart_tx's sent output.
//  One instance per transmitter (keyboard side, board side). Clocked by the same tick (baud) as uart_tx.
// PARAMETERS
//  DEPTH_LOG2  4     FIFO depth = 2**DEPTH_LOG2 bytes (16)
//  GAP_CYCLES  2     idle clk cycles inserted after each completed byte, before the next release
//  TIMEOUT     4096  max clk cycles in WAIT for a sent edge; counter is 16 bits wide
// PORTS
//  clk          in   1             clock (baud tick domain); all logic on posedge
//  reset        in   1             asynchronous, active-high; clears FIFO, FSM and flags
//  wr_en        in   1             push wr_data this cycle (single-cycle pulse or level; one push per high cycle)
//  wr_data      in   8             byte to queue
//  clr_err      in   1             synchronous clear of overflow and timeout_err
//  tx_sent      in   1             sent output of uart_tx; rising edge = byte finished
//  tx_data      out  8             byte presented to uart_tx (registered, stable from release through WAIT)
//  tx_en        out  1             one-cycle start pulse to uart_tx
//  full         out  1             count == 2**DEPTH_LOG2
//  empty        out  1             count == 0
//  count        out  DEPTH_LOG2+1  bytes currently queued (excludes the byte in flight)
//  busy         out  1             FSM not in IDLE
//  overflow     out  1             sticky: a write was dropped
//  timeout_err  out  1             sticky: a WAIT timed out
// BEHAVIOUR
//  Reset (async assert): FIFO pointers 0, count 0, empty 1, full 0, tx_data 8'h00, tx_en 0,
//    busy 0, overflow 0, timeout_err 0, FSM IDLE, sent_prev 0, timers 0.
//  FIFO
//    - Circular buffer, pointers wrap modulo 2**DEPTH_LOG2.
//    - Order is strictly first-in first-out.
//    - Write when !full: stored at wr_ptr, count+1.
//    - Write when full with no pop that cycle: byte dropped, overflow<=1, count unchanged.
//    - Write when full with a pop the same cycle: accepted; count unchanged.
//    - Write and pop the same cycle when empty is impossible (pop needs !empty); the written byte waits for the next IDLE.
//  Edge detect: sent_prev <= tx_sent every cycle; sent_rise = tx_sent & ~sent_prev.
//  FSM states: IDLE, START, WAIT, GAP.
//    - IDLE: if !empty -> tx_data<=head, pop (rd_ptr+1, count-1), go START. Otherwise stay.
//    - START: tx_en=1 for exactly this cycle; go WAIT; clear the timeout counter.
//      A sent_rise here is ignored.
//    - WAIT: on sent_rise -> GAP; clear the gap counter.
//      Otherwise count+1; when the count reaches TIMEOUT-1 without sent_rise -> timeout_err<=1, go IDLE (byte abandoned).
//    - GAP: stay GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0 means GAP lasts one cycle.
//  Latency: wr_en in cycle N into an empty, idle queue -> tx_data valid from cycle N+2, tx_en high in cycle N+2.
//  Throughput: one byte per uart frame + GAP_CYCLES+2 cycles.
//  tx_en is never high outside START; tx_data changes only on a pop in IDLE.
//  clr_err has priority below a same-cycle set: if an overflow or timeout occurs in the same cycle as clr_err, the flag ends at 1.
//  Reset mid-operation (any state): everything returns to reset values immediately, queued bytes are lost,
//    and no tx_en is issued until a new write.
// TESTING
//  1 Single byte: reset, wr 8'h41 in cycle 0 -> tx_en=1 and tx_data=8'h41 in cycle 2 only; busy=1;
//    pulse tx_sent -> IDLE after GAP, count=0.
//  2 Ordering: write 8'h01,8'h02,8'h03 back-to-back; model uart_tx with a 20-cycle sent delay ->
//    three tx_en pulses carrying 01,02,03 in order, each separated by >= 22 cycles.
//  3 Overflow: hold tx_sent low, write 18 bytes 8'h10..8'h21 -> first byte in flight, count=16, full=1,
//    8'h21 dropped, overflow=1; clr_err -> 0.
//  4 Full + pop same cycle: fill to 16 while in GAP, write as FSM pops in IDLE -> accepted, count stays 16, no overflow.
//  5 Timeout: TIMEOUT=16, write 8'hAA, never raise tx_sent -> timeout_err=1 after 15 WAIT cycles; next byte released normally.
//  6 Reset in WAIT with 5 bytes queued -> all outputs at reset values same cycle, empty=1, no tx_en afterwards.

Source files
------------

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and paced send sequencer in front of a uart_tx instance
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  clr_err,
    input  logic                  tx_sent,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int                  DEPTH        = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT    = (DEPTH_LOG2 + 1)'(DEPTH);
    // Timer value at which the next increment would reach TIMEOUT-1.
    localparam logic [15:0]         TIMEOUT_LAST = 16'(TIMEOUT - 2);
    // GAP_CYCLES of 0 and 1 both give a single GAP cycle.
    localparam logic [15:0]         GAP_LAST     = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [15:0]             timer;
    logic [15:0]             gap_cnt;
    logic                    sent_prev;
    logic                    sent_rise;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic                    timer_clr;
    logic                    timer_inc;
    logic                    gap_clr;
    logic                    gap_inc;
    logic                    timeout_set;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign busy      = (state != S_IDLE);
    assign sent_rise = tx_sent & ~sent_prev;
    // A pop in the same cycle frees a slot, so a write into a full queue is still accepted.
    assign push      = wr_en & (~full | pop);
    assign drop      = wr_en & full & ~pop;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        tx_en       = 1'b0;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        gap_clr     = 1'b0;
        gap_inc     = 1'b0;
        timeout_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = S_START;
                end
            end
            S_START: begin
                tx_en      = 1'b1;
                timer_clr  = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (sent_rise) begin
                    gap_clr    = 1'b1;
                    next_state = S_GAP;
                end else if (timer == TIMEOUT_LAST) begin
                    timeout_set = 1'b1;
                    next_state  = S_IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt >= GAP_LAST) next_state = S_IDLE;
                else                     gap_inc    = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output byte register, edge detector and WAIT/GAP timers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data   <= 8'h00;
            sent_prev <= 1'b0;
            timer     <= '0;
            gap_cnt   <= '0;
        end else begin
            sent_prev <= tx_sent;
            if (pop)            tx_data <= mem[rd_ptr];
            if (timer_clr)      timer   <= '0;
            else if (timer_inc) timer   <= timer + 1'b1;
            if (gap_clr)        gap_cnt <= '0;
            else if (gap_inc)   gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Sticky error flags; a same-cycle set wins over clr_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (drop)         overflow    <= 1'b1;
            else if (clr_err) overflow    <= 1'b0;
            if (timeout_set)  timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end

endmodule
